// File: rtl/load_store_buffer.sv
// In-order load/store queue between dispatch and the memory controller. Snoops result
// broadcasts, hands resolved stores to the ROB at the head and issues loads in program order.
module load_store_buffer #(
   parameter int unsigned            XLEN           = 32,
   parameter int unsigned            LSB_SIZE_WIDTH = 3,
   parameter int unsigned            ROB_SIZE_WIDTH = 3,
   parameter int unsigned            DEP_WIDTH      = ROB_SIZE_WIDTH + 1,
   parameter int unsigned            OP_WIDTH       = 6,
   parameter logic [XLEN-1:0]        IO_ADDR        = 32'h30000,
   parameter logic [OP_WIDTH-1:0]    OP_LB          = 6'd11,
   parameter logic [OP_WIDTH-1:0]    OP_LH          = 6'd12,
   parameter logic [OP_WIDTH-1:0]    OP_LW          = 6'd13,
   parameter logic [OP_WIDTH-1:0]    OP_LBU         = 6'd14,
   parameter logic [OP_WIDTH-1:0]    OP_LHU         = 6'd15,
   parameter logic [OP_WIDTH-1:0]    OP_SB          = 6'd16,
   parameter logic [OP_WIDTH-1:0]    OP_SH          = 6'd17,
   parameter logic [OP_WIDTH-1:0]    OP_SW          = 6'd18
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      flush,
   input  logic                      stall,
   input  logic                      dis_valid,
   input  logic [OP_WIDTH-1:0]       dis_op,
   input  logic [ROB_SIZE_WIDTH-1:0] dis_id,
   input  logic [XLEN-1:0]           dis_imm,
   input  logic [DEP_WIDTH-1:0]      dis_Q1,
   input  logic [DEP_WIDTH-1:0]      dis_Q2,
   input  logic [XLEN-1:0]           dis_V1,
   input  logic [XLEN-1:0]           dis_V2,
   input  logic                      alu_ready,
   input  logic [ROB_SIZE_WIDTH-1:0] alu_id,
   input  logic [XLEN-1:0]           alu_res,
   input  logic                      mem_data_ready,
   input  logic [ROB_SIZE_WIDTH-1:0] mem_id,
   input  logic [XLEN-1:0]           mem_data,
   input  logic                      mem_busy,
   input  logic [ROB_SIZE_WIDTH-1:0] rob_head_id,
   input  logic                      rob_store_commit,
   output logic                      lsb_full,
   output logic                      lsb_empty,
   output logic [OP_WIDTH-1:0]       lsb_front_op,
   output logic [ROB_SIZE_WIDTH-1:0] lsb_front_id,
   output logic [DEP_WIDTH-1:0]      lsb_front_Q1,
   output logic [DEP_WIDTH-1:0]      lsb_front_Q2,
   output logic [XLEN-1:0]           lsb_front_V1,
   output logic [XLEN-1:0]           lsb_front_V2,
   output logic                      lsb_mem_enable,
   output logic [OP_WIDTH-1:0]       lsb_mem_op,
   output logic [XLEN-1:0]           lsb_mem_addr,
   output logic [ROB_SIZE_WIDTH-1:0] lsb_mem_id
);

   localparam int unsigned LSB_SIZE = 1 << LSB_SIZE_WIDTH;
   localparam logic [DEP_WIDTH-1:0] NO_DEP = '1;
   localparam logic [LSB_SIZE_WIDTH:0] FULL_COUNT = {1'b1, {LSB_SIZE_WIDTH{1'b0}}};

   logic [LSB_SIZE-1:0]       valid_q, valid_d;
   logic [OP_WIDTH-1:0]       op_q  [LSB_SIZE];
   logic [OP_WIDTH-1:0]       op_d  [LSB_SIZE];
   logic [ROB_SIZE_WIDTH-1:0] id_q  [LSB_SIZE];
   logic [ROB_SIZE_WIDTH-1:0] id_d  [LSB_SIZE];
   logic [XLEN-1:0]           imm_q [LSB_SIZE];
   logic [XLEN-1:0]           imm_d [LSB_SIZE];
   logic [DEP_WIDTH-1:0]      q1_q  [LSB_SIZE];
   logic [DEP_WIDTH-1:0]      q1_d  [LSB_SIZE];
   logic [DEP_WIDTH-1:0]      q2_q  [LSB_SIZE];
   logic [DEP_WIDTH-1:0]      q2_d  [LSB_SIZE];
   logic [XLEN-1:0]           v1_q  [LSB_SIZE];
   logic [XLEN-1:0]           v1_d  [LSB_SIZE];
   logic [XLEN-1:0]           v2_q  [LSB_SIZE];
   logic [XLEN-1:0]           v2_d  [LSB_SIZE];

   logic [LSB_SIZE_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [LSB_SIZE_WIDTH:0]   count_q, count_d;
   logic [ROB_SIZE_WIDTH:0]   pending_q, pending_d;
   logic                      mem_en_d;
   logic [OP_WIDTH-1:0]       mem_op_d;
   logic [XLEN-1:0]           mem_addr_d;
   logic [ROB_SIZE_WIDTH-1:0] mem_id_d;

   logic front_is_load, front_is_store, enq, store_pop, load_go, pop;
   logic [DEP_WIDTH-1:0] enq_q1, enq_q2;
   logic [XLEN-1:0]      enq_v1, enq_v2;

   assign lsb_empty    = (count_q == '0);
   assign lsb_full     = (count_q == FULL_COUNT);
   assign lsb_front_op = op_q[head_q];
   assign lsb_front_id = id_q[head_q];
   assign lsb_front_Q1 = q1_q[head_q];
   assign lsb_front_Q2 = q2_q[head_q];
   assign lsb_front_V1 = v1_q[head_q] + imm_q[head_q];
   assign lsb_front_V2 = v2_q[head_q];

   assign front_is_load  = lsb_front_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   assign front_is_store = lsb_front_op inside {OP_SB, OP_SH, OP_SW};

   assign enq       = dis_valid && !stall && !lsb_full;
   assign store_pop = !lsb_empty && front_is_store && lsb_front_Q1 == NO_DEP &&
                      lsb_front_Q2 == NO_DEP;
   // IO loads have side effects, so they only go once they are the oldest instruction.
   assign load_go   = !lsb_empty && front_is_load && lsb_front_Q1 == NO_DEP && !mem_busy &&
                      pending_q == '0 &&
                      (lsb_front_V1 != IO_ADDR || lsb_front_id == rob_head_id);
   assign pop       = store_pop || load_go;

   // Operands arriving on a broadcast in the dispatch cycle are captured already resolved.
   always_comb begin
      enq_q1 = dis_Q1;
      enq_v1 = dis_V1;
      enq_q2 = dis_Q2;
      enq_v2 = dis_V2;
      if (alu_ready && dis_Q1 == {1'b0, alu_id}) begin
         enq_q1 = NO_DEP;
         enq_v1 = alu_res;
      end else if (mem_data_ready && dis_Q1 == {1'b0, mem_id}) begin
         enq_q1 = NO_DEP;
         enq_v1 = mem_data;
      end
      if (alu_ready && dis_Q2 == {1'b0, alu_id}) begin
         enq_q2 = NO_DEP;
         enq_v2 = alu_res;
      end else if (mem_data_ready && dis_Q2 == {1'b0, mem_id}) begin
         enq_q2 = NO_DEP;
         enq_v2 = mem_data;
      end
   end

   always_comb begin
      valid_d    = valid_q;
      op_d       = op_q;
      id_d       = id_q;
      imm_d      = imm_q;
      q1_d       = q1_q;
      q2_d       = q2_q;
      v1_d       = v1_q;
      v2_d       = v2_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      pending_d  = pending_q;
      mem_en_d   = 1'b0;
      mem_op_d   = lsb_mem_op;
      mem_addr_d = lsb_mem_addr;
      mem_id_d   = lsb_mem_id;

      for (int i = 0; i < LSB_SIZE; i++) begin
         if (valid_q[i]) begin
            if (alu_ready && q1_q[i] == {1'b0, alu_id}) begin
               q1_d[i] = NO_DEP;
               v1_d[i] = alu_res;
            end else if (mem_data_ready && q1_q[i] == {1'b0, mem_id}) begin
               q1_d[i] = NO_DEP;
               v1_d[i] = mem_data;
            end
            if (alu_ready && q2_q[i] == {1'b0, alu_id}) begin
               q2_d[i] = NO_DEP;
               v2_d[i] = alu_res;
            end else if (mem_data_ready && q2_q[i] == {1'b0, mem_id}) begin
               q2_d[i] = NO_DEP;
               v2_d[i] = mem_data;
            end
         end
      end

      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      if (enq) begin
         valid_d[tail_q] = 1'b1;
         op_d[tail_q]    = dis_op;
         id_d[tail_q]    = dis_id;
         imm_d[tail_q]   = dis_imm;
         q1_d[tail_q]    = enq_q1;
         v1_d[tail_q]    = enq_v1;
         q2_d[tail_q]    = enq_q2;
         v2_d[tail_q]    = enq_v2;
         tail_d          = tail_q + 1'b1;
      end

      unique case ({enq, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      unique case ({store_pop, rob_store_commit})
         2'b10:   pending_d = pending_q + 1'b1;
         2'b01:   pending_d = pending_q - 1'b1;
         default: pending_d = pending_q;
      endcase

      if (load_go) begin
         mem_en_d   = 1'b1;
         mem_op_d   = lsb_front_op;
         mem_addr_d = lsb_front_V1;
         mem_id_d   = lsb_front_id;
      end

      if (flush) begin
         valid_d   = '0;
         head_d    = tail_q;
         tail_d    = tail_q;
         count_d   = '0;
         pending_d = '0;
         mem_en_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rdy) begin
         if (rst) begin
            valid_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            pending_q      <= '0;
            lsb_mem_enable <= 1'b0;
            lsb_mem_op     <= '0;
            lsb_mem_addr   <= '0;
            lsb_mem_id     <= '0;
            for (int i = 0; i < LSB_SIZE; i++) begin
               op_d_reset(i);
            end
         end else begin
            valid_q        <= valid_d;
            op_q           <= op_d;
            id_q           <= id_d;
            imm_q          <= imm_d;
            q1_q           <= q1_d;
            q2_q           <= q2_d;
            v1_q           <= v1_d;
            v2_q           <= v2_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            pending_q      <= pending_d;
            lsb_mem_enable <= mem_en_d;
            lsb_mem_op     <= mem_op_d;
            lsb_mem_addr   <= mem_addr_d;
            lsb_mem_id     <= mem_id_d;
         end
      end
   end

   task automatic op_d_reset(input int i);
      op_q[i]  <= '0;
      id_q[i]  <= '0;
      imm_q[i] <= '0;
      q1_q[i]  <= NO_DEP;
      q2_q[i]  <= NO_DEP;
      v1_q[i]  <= '0;
      v2_q[i]  <= '0;
   endtask

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed self-checking bench for load_store_buffer: a vector table of single memory ops
// plus hand-written sequences for snooping, store ordering, IO loads, fill/wrap and flush.
module tb_load_store_buffer;

   localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;
   localparam logic [5:0] SB = 6'd16, SH = 6'd17, SW = 6'd18;
   localparam logic [3:0] ND = 4'hF;

   logic        clk = 1'b0, rst, rdy, flush, stall;
   logic        dis_valid;
   logic [5:0]  dis_op;
   logic [2:0]  dis_id;
   logic [31:0] dis_imm, dis_V1, dis_V2;
   logic [3:0]  dis_Q1, dis_Q2;
   logic        alu_ready, mem_data_ready, mem_busy, rob_store_commit;
   logic [2:0]  alu_id, mem_id, rob_head_id;
   logic [31:0] alu_res, mem_data;
   logic        lsb_full, lsb_empty, lsb_mem_enable;
   logic [5:0]  lsb_front_op, lsb_mem_op;
   logic [2:0]  lsb_front_id, lsb_mem_id;
   logic [3:0]  lsb_front_Q1, lsb_front_Q2;
   logic [31:0] lsb_front_V1, lsb_front_V2, lsb_mem_addr;

   int n_pass = 0;
   int n_total = 0;

   load_store_buffer dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall(stall),
      .dis_valid(dis_valid), .dis_op(dis_op), .dis_id(dis_id), .dis_imm(dis_imm),
      .dis_Q1(dis_Q1), .dis_Q2(dis_Q2), .dis_V1(dis_V1), .dis_V2(dis_V2),
      .alu_ready(alu_ready), .alu_id(alu_id), .alu_res(alu_res),
      .mem_data_ready(mem_data_ready), .mem_id(mem_id), .mem_data(mem_data),
      .mem_busy(mem_busy), .rob_head_id(rob_head_id), .rob_store_commit(rob_store_commit),
      .lsb_full(lsb_full), .lsb_empty(lsb_empty),
      .lsb_front_op(lsb_front_op), .lsb_front_id(lsb_front_id),
      .lsb_front_Q1(lsb_front_Q1), .lsb_front_Q2(lsb_front_Q2),
      .lsb_front_V1(lsb_front_V1), .lsb_front_V2(lsb_front_V2),
      .lsb_mem_enable(lsb_mem_enable), .lsb_mem_op(lsb_mem_op),
      .lsb_mem_addr(lsb_mem_addr), .lsb_mem_id(lsb_mem_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [2:0]  id;
      logic [31:0] imm;
      logic [31:0] v1;
      logic [31:0] v2;
      logic        is_load;
      logic [31:0] addr;
   } vec_t;

   vec_t vecs[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic dispatch(input logic [5:0] op, input logic [2:0] id, input logic [31:0] imm,
                           input logic [3:0] q1, input logic [31:0] v1,
                           input logic [3:0] q2, input logic [31:0] v2);
      dis_op = op; dis_id = id; dis_imm = imm;
      dis_Q1 = q1; dis_V1 = v1; dis_Q2 = q2; dis_V2 = v2;
      dis_valid = 1'b1;
      step();
      dis_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic commit_pulse();
      rob_store_commit = 1'b1;
      step();
      rob_store_commit = 1'b0;
   endtask

   initial begin
      vecs[0] = '{LW,  3'd1, 32'h0,        32'h100,      32'h0,        1'b1, 32'h100};
      vecs[1] = '{LB,  3'd2, 32'h4,        32'h1000,     32'h0,        1'b1, 32'h1004};
      vecs[2] = '{LHU, 3'd3, 32'hFFFFFFFC, 32'h2000,     32'h0,        1'b1, 32'h1FFC};
      vecs[3] = '{SW,  3'd4, 32'h10,       32'h300,      32'hDEADBEEF, 1'b0, 32'h310};
      vecs[4] = '{SB,  3'd5, 32'h1,        32'hFFFFFFFF, 32'h55,       1'b0, 32'h0};
      vecs[5] = '{LH,  3'd7, 32'h8,        32'h7FF8,     32'h0,        1'b1, 32'h8000};

      rdy = 1'b1; flush = 1'b0; stall = 1'b0; dis_valid = 1'b0;
      dis_op = '0; dis_id = '0; dis_imm = '0; dis_Q1 = ND; dis_Q2 = ND; dis_V1 = '0;
      dis_V2 = '0; alu_ready = 1'b0; alu_id = '0; alu_res = '0; mem_data_ready = 1'b0;
      mem_id = '0; mem_data = '0; mem_busy = 1'b0; rob_head_id = '0; rob_store_commit = 1'b0;
      do_reset();

      check("reset_empty", lsb_empty, 1);
      check("reset_full", lsb_full, 0);
      check("reset_mem_en", lsb_mem_enable, 0);
      check("reset_mem_addr", lsb_mem_addr, 0);
      check("reset_mem_op", lsb_mem_op, 0);

      for (int i = 0; i < 6; i++) begin
         dispatch(vecs[i].op, vecs[i].id, vecs[i].imm, ND, vecs[i].v1, ND, vecs[i].v2);
         check("vec_front_addr", lsb_front_V1, vecs[i].addr);
         check("vec_front_id", lsb_front_id, vecs[i].id);
         check("vec_not_empty", lsb_empty, 0);
         if (vecs[i].is_load) begin
            check("vec_mem_en_early", lsb_mem_enable, 0);
            step();
            check("vec_mem_en", lsb_mem_enable, 1);
            check("vec_mem_addr", lsb_mem_addr, vecs[i].addr);
            check("vec_mem_op", lsb_mem_op, vecs[i].op);
            check("vec_mem_id", lsb_mem_id, vecs[i].id);
            check("vec_load_popped", lsb_empty, 1);
            step();
            check("vec_mem_pulse", lsb_mem_enable, 0);
         end else begin
            check("vec_front_v2", lsb_front_V2, vecs[i].v2);
            step();
            check("vec_store_popped", lsb_empty, 1);
            check("vec_store_no_mem", lsb_mem_enable, 0);
            commit_pulse();
         end
      end

      // Store waiting on ALU (rs1) and memory (rs2) results, then a load held behind it.
      do_reset();
      dispatch(SW, 3'd1, 32'h8, 4'd3, 32'h0, 4'd2, 32'h0);
      check("st_q1_pending", lsb_front_Q1, 3);
      alu_ready = 1'b1; alu_id = 3'd3; alu_res = 32'h200;
      step();
      alu_ready = 1'b0;
      check("st_q1_resolved", lsb_front_Q1, ND);
      check("st_addr", lsb_front_V1, 32'h208);
      check("st_wait_q2", lsb_empty, 0);
      mem_data_ready = 1'b1; mem_id = 3'd2; mem_data = 32'hAB;
      step();
      mem_data_ready = 1'b0;
      check("st_q2_resolved", lsb_front_Q2, ND);
      check("st_data", lsb_front_V2, 32'hAB);
      step();
      check("st_popped", lsb_empty, 1);
      dispatch(LW, 3'd2, 32'h0, ND, 32'h40, ND, 32'h0);
      step();
      check("ld_held_1", lsb_mem_enable, 0);
      step();
      check("ld_held_2", lsb_mem_enable, 0);
      check("ld_still_queued", lsb_empty, 0);
      commit_pulse();
      check("ld_held_commit_cycle", lsb_mem_enable, 0);
      step();
      check("ld_after_commit", lsb_mem_enable, 1);
      check("ld_after_commit_addr", lsb_mem_addr, 32'h40);

      // IO load with rs1 captured from a same-cycle ALU broadcast; waits to be ROB head.
      do_reset();
      rob_head_id = 3'd4;
      alu_ready = 1'b1; alu_id = 3'd1; alu_res = 32'h30000;
      dispatch(LW, 3'd5, 32'h0, 4'd1, 32'h0, ND, 32'h0);
      alu_ready = 1'b0;
      check("io_enq_capture_q", lsb_front_Q1, ND);
      check("io_enq_capture_v", lsb_front_V1, 32'h30000);
      step();
      check("io_held_1", lsb_mem_enable, 0);
      step();
      check("io_held_2", lsb_mem_enable, 0);
      rob_head_id = 3'd5;
      step();
      check("io_issued", lsb_mem_enable, 1);
      check("io_addr", lsb_mem_addr, 32'h30000);
      check("io_id", lsb_mem_id, 5);
      rdy = 1'b0;
      step();
      check("rdy_low_hold", lsb_mem_enable, 1);
      rdy = 1'b1;
      step();
      check("io_pulse_end", lsb_mem_enable, 0);
      rob_head_id = 3'd0;

      // Fill all eight slots with unresolved stores, drop a ninth, then pop and refill.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         dispatch(SW, 3'(i), 32'h0, {1'b0, 3'(i)}, 32'h0, ND, 32'(i));
      end
      check("fill_full", lsb_full, 1);
      check("fill_front_id", lsb_front_id, 0);
      dispatch(SW, 3'd6, 32'h0, ND, 32'h0, ND, 32'h99);
      check("ninth_dropped_full", lsb_full, 1);
      check("ninth_front_id", lsb_front_id, 0);
      alu_ready = 1'b1; alu_id = 3'd0; alu_res = 32'h500;
      step();
      alu_ready = 1'b0;
      check("fill_head_resolved", lsb_front_V1, 32'h500);
      check("fill_head_still_full", lsb_full, 1);
      step();
      check("fill_pop_not_full", lsb_full, 0);
      check("fill_pop_next_id", lsb_front_id, 1);
      dispatch(SW, 3'd2, 32'h0, 4'd6, 32'h0, ND, 32'h0);
      check("refill_full", lsb_full, 1);
      check("refill_front_id", lsb_front_id, 1);

      // Flush with a pending store and a same-cycle dispatch; afterwards a load issues at once.
      do_reset();
      dispatch(SW, 3'd0, 32'h0, ND, 32'h10, ND, 32'h1);
      step();
      check("fl_store_popped", lsb_empty, 1);
      for (int i = 0; i < 4; i++) begin
         dispatch(LW, 3'(i + 1), 32'h0, 4'd7, 32'h0, ND, 32'h0);
      end
      check("fl_four_queued", lsb_empty, 0);
      dis_op = LW; dis_id = 3'd6; dis_Q1 = ND; dis_V1 = 32'h900; dis_imm = 32'h0;
      dis_valid = 1'b1; flush = 1'b1;
      step();
      dis_valid = 1'b0; flush = 1'b0;
      check("fl_empty", lsb_empty, 1);
      check("fl_no_mem", lsb_mem_enable, 0);
      step();
      check("fl_dispatch_ignored", lsb_mem_enable, 0);
      mem_busy = 1'b1;
      dispatch(LW, 3'd6, 32'h0, ND, 32'h80, ND, 32'h0);
      step();
      check("fl_mem_busy_hold", lsb_mem_enable, 0);
      mem_busy = 1'b0;
      step();
      check("fl_pending_cleared", lsb_mem_enable, 1);
      check("fl_load_addr", lsb_mem_addr, 32'h80);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
